vga_coord_gen: RTL



---
 rtl/vga_coord_gen_if.sv | 17 +
 rtl/vga_coord_gen.sv | 64 ++++++
 2 files changed

// File: rtl/vga_coord_gen_if.sv
// vga_coord_gen_if: coordinate, sync and strobe bundle from the timing generator to pixel-test blocks
interface vga_coord_gen_if;
  logic [11:0] VGA_horzCoord;
  logic [11:0] VGA_vertCoord;
  logic VGA_HS;
  logic VGA_VS;
  logic VGA_active;
  logic PIX_EN;
  logic LINE_END;
  logic FRAME_START;
  modport master (
    output VGA_horzCoord, VGA_vertCoord, VGA_HS, VGA_VS, VGA_active, PIX_EN, LINE_END, FRAME_START
  );
  modport slave (
    input VGA_horzCoord, VGA_vertCoord, VGA_HS, VGA_VS, VGA_active, PIX_EN, LINE_END, FRAME_START
  );
endinterface

// File: rtl/vga_coord_gen.sv
// vga_coord_gen: VGA pixel-enable divider, h/v counters and registered sync/active/strobe decode
module vga_coord_gen #(
  parameter int CLK_DIV = 1,
  parameter int H_ACTIVE = 1280,
  parameter int H_FP = 48,
  parameter int H_SYNC = 112,
  parameter int H_BP = 248,
  parameter int V_ACTIVE = 1024,
  parameter int V_FP = 1,
  parameter int V_SYNC = 3,
  parameter int V_BP = 38,
  parameter bit SYNC_POL = 1'b1
) (
  input logic CLK,
  input logic RESET,
  vga_coord_gen_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  logic [3:0] div, divNext;
  logic [11:0] h, v, hNext, vNext;
  logic pixEn, pixEnNext, activeNext, hsNext, vsNext, lineEndNext, frameStartNext;
  int hi, vi;
  // Coordinates advance on the edge after a PIX_EN cycle; flags decode the post-edge pixel so nothing skews
  always_comb begin
    pixEnNext = div == 4'(CLK_DIV - 1);
    divNext = pixEnNext ? 4'd0 : div + 4'd1;
    hNext = pixEn ? (h == 12'(H_TOTAL - 1) ? 12'd0 : h + 12'd1) : h;
    vNext = (pixEn && h == 12'(H_TOTAL - 1)) ? (v == 12'(V_TOTAL - 1) ? 12'd0 : v + 12'd1) : v;
    hi = int'(hNext);
    vi = int'(vNext);
    activeNext = hi < H_ACTIVE && vi < V_ACTIVE;
    hsNext = (hi >= H_ACTIVE + H_FP && hi < H_ACTIVE + H_FP + H_SYNC) ? SYNC_POL : !SYNC_POL;
    vsNext = (vi >= V_ACTIVE + V_FP && vi < V_ACTIVE + V_FP + V_SYNC) ? SYNC_POL : !SYNC_POL;
    lineEndNext = pixEnNext && hi == H_TOTAL - 1;
    frameStartNext = pixEnNext && hi == 0 && vi == 0;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      div <= '0;
      h <= '0;
      v <= '0;
      pixEn <= 1'b0;
      vga.VGA_active <= 1'b0;
      vga.VGA_HS <= !SYNC_POL;
      vga.VGA_VS <= !SYNC_POL;
      vga.LINE_END <= 1'b0;
      vga.FRAME_START <= 1'b0;
    end else begin
      div <= divNext;
      h <= hNext;
      v <= vNext;
      pixEn <= pixEnNext;
      vga.VGA_active <= activeNext;
      vga.VGA_HS <= hsNext;
      vga.VGA_VS <= vsNext;
      vga.LINE_END <= lineEndNext;
      vga.FRAME_START <= frameStartNext;
    end
  end
  assign vga.VGA_horzCoord = h;
  assign vga.VGA_vertCoord = v;
  assign vga.PIX_EN = pixEn;
endmodule
